// File: rtl/ws2801_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : ws2801_driver_if
//  Description : Frame request/status, color-memory read port and LED chain
//                pins shared by the WS2801 driver and its environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface ws2801_driver_if #(
  parameter int LEDS = 50
);
  localparam int ADDR_W = (LEDS > 1) ? $clog2(LEDS) : 1;

  logic              start;    // request one frame
  logic [ADDR_W-1:0] rd_addr;  // LED index presented to the color memory
  logic [23:0]       rd_data;  // {R, G, B}, valid one cycle after rd_addr
  logic              sdo;      // serial data to LED 0
  logic              cko;      // serial clock to LED 0
  logic              busy;     // frame in progress
  logic              done;     // one-cycle pulse after the latch gap

  // Environment side: requests frames and answers memory reads.
  modport master (
    output start,
    output rd_data,
    input  rd_addr,
    input  sdo,
    input  cko,
    input  busy,
    input  done
  );

  // Driver side.
  modport slave (
    input  start,
    input  rd_data,
    output rd_addr,
    output sdo,
    output cko,
    output busy,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/ws2801_driver.sv
`default_nettype none
// ============================================================================
//  Module      : ws2801_driver
//  Description : Streams one frame of 24-bit colors, read from a synchronous
//                color memory, onto a WS2801 SDI/CKI chain, then holds CKI low
//                for the latch gap and pulses done.
//  Revision    : 1.0  initial release
// ============================================================================
module ws2801_driver #(
  parameter int LEDS         = 50,
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 25000
) (
  input wire             clk,
  input wire             rst,
  ws2801_driver_if.slave bus
);

  localparam int ADDR_W = (LEDS > 1) ? $clog2(LEDS) : 1;
  localparam int PH_W   = $clog2(CLK_DIV + 1);
  localparam int LAT_W  = $clog2(LATCH_CYCLES + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LEDS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [PH_W-1:0]   PH_MAX   = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0]   PH_ONE   = PH_W'(1);
  localparam logic [LAT_W-1:0]  LAT_MAX  = LAT_W'(LATCH_CYCLES);
  localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);
  localparam logic [4:0]        LAST_BIT = 5'd23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;         // current LED, doubles as the read address
  logic              r_fetch_2nd;   // second FETCH cycle: memory data is valid
  logic [23:0]       r_shreg;       // bit 23 is the bit currently on sdo
  logic [PH_W-1:0]   r_phase;       // cycles elapsed in the current cko half
  logic [4:0]        r_bit_cnt;     // bit index within the current LED
  logic [LAT_W-1:0]  r_latch_cnt;   // cycles elapsed in the latch gap
  logic              r_sdo;
  logic              r_cko;
  logic              r_busy;
  logic              r_done;

  assign bus.rd_addr = r_idx;
  assign bus.sdo     = r_sdo;
  assign bus.cko     = r_cko;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

  // Frame sequencer: fetch a color, shift its 24 bits out, repeat per LED, then
  // hold the chain clock low long enough for every LED to latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_fetch_2nd <= 1'b0;
      r_shreg     <= '0;
      r_phase     <= PH_ONE;
      r_bit_cnt   <= '0;
      r_latch_cnt <= LAT_ONE;
      r_sdo       <= 1'b0;
      r_cko       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state     <= FETCH;
            r_idx       <= '0;
            r_fetch_2nd <= 1'b0;
            r_busy      <= 1'b1;
          end
        end

        FETCH: begin
          // The address went out on entry; data shows up one cycle later.
          if (!r_fetch_2nd) begin
            r_fetch_2nd <= 1'b1;
          end else begin
            r_shreg   <= bus.rd_data;
            r_sdo     <= bus.rd_data[23];
            r_cko     <= 1'b0;
            r_phase   <= PH_ONE;
            r_bit_cnt <= '0;
            r_state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (r_phase != PH_MAX) begin
            r_phase <= r_phase + PH_ONE;
          end else begin
            r_phase <= PH_ONE;
            if (!r_cko) begin
              // Data has been settled for a full half period: raise the clock.
              r_cko <= 1'b1;
            end else begin
              r_cko <= 1'b0;
              if (r_bit_cnt != LAST_BIT) begin
                // Rotating keeps the register full; only bit 23 is ever used.
                r_bit_cnt <= r_bit_cnt + 5'd1;
                r_shreg   <= {r_shreg[22:0], r_shreg[23]};
                r_sdo     <= r_shreg[22];
              end else if (r_idx != LAST_IDX) begin
                // sdo keeps the last bit while the next color is fetched.
                r_idx       <= r_idx + IDX_ONE;
                r_fetch_2nd <= 1'b0;
                r_state     <= FETCH;
              end else begin
                r_sdo       <= 1'b0;
                r_latch_cnt <= LAT_ONE;
                r_state     <= LATCH;
              end
            end
          end
        end

        LATCH: begin
          if (r_latch_cnt == LAT_MAX) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_latch_cnt <= r_latch_cnt + LAT_ONE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ws2801_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws2801_driver
//  Description : Bench for ws2801_driver: two instances (3 LEDs / CLK_DIV=2
//                and 50 LEDs / CLK_DIV=1), frame-timeline reference model,
//                chained-LED capture of the serial stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ws2801_driver;

  localparam int A_LEDS = 3;
  localparam int A_CD   = 2;
  localparam int A_LC   = 20;
  localparam int B_LEDS = 50;
  localparam int B_CD   = 1;
  localparam int B_LC   = 16;
  localparam int A_FRAME = A_LEDS * (2 + 48 * A_CD) + A_LC;
  localparam int B_FRAME = B_LEDS * (2 + 48 * B_CD) + B_LC;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks   = 0;
  int   failures = 0;

  logic [23:0] mem_a [A_LEDS];
  logic [23:0] nxt_a [A_LEDS];
  logic [23:0] a_got [A_LEDS];
  logic [23:0] mem_b [B_LEDS];
  bit          a_q [$];
  bit          b_q [$];

  initial forever #5 clk = ~clk;

  ws2801_driver_if #(.LEDS(A_LEDS)) bif_a ();
  ws2801_driver_if #(.LEDS(B_LEDS)) bif_b ();

  ws2801_driver #(.LEDS(A_LEDS), .CLK_DIV(A_CD), .LATCH_CYCLES(A_LC)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bif_a)
  );

  ws2801_driver #(.LEDS(B_LEDS), .CLK_DIV(B_CD), .LATCH_CYCLES(B_LC)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bif_b)
  );

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Where cycle t (0 = first cycle with busy high) of a frame sits:
  // kind 0 = fetch, 1 = shifting, 2 = latch gap.
  function automatic void frame_pos(input int leds, input int cd, input int t,
                                    output int kind, output int led, output int bn,
                                    output bit hi);
    int p, r, s;
    p    = 2 + 48 * cd;
    kind = 2;
    led  = leds - 1;
    bn   = 0;
    hi   = 1'b0;
    if (t < leds * p) begin
      led = t / p;
      r   = t % p;
      if (r < 2) begin
        kind = 0;
      end else begin
        kind = 1;
        s    = r - 2;
        bn   = s / (2 * cd);
        hi   = (s % (2 * cd)) >= cd;
      end
    end
  endfunction

  // Memory for instance A: address 1 yields valid data only in the single
  // cycle after it is first presented; later cycles return garbage.
  initial begin : mem_port_a
    int prev_addr;
    prev_addr = -1;
    bif_a.rd_data = '0;
    forever begin
      @(posedge clk);
      if (int'(bif_a.rd_addr) == 1 && prev_addr != 1)
        bif_a.rd_data <= mem_a[1];
      else if (int'(bif_a.rd_addr) == 1)
        bif_a.rd_data <= 24'($urandom);
      else
        bif_a.rd_data <= mem_a[bif_a.rd_addr];
      prev_addr = int'(bif_a.rd_addr);
    end
  end

  initial begin : mem_port_b
    bif_b.rd_data = '0;
    forever begin
      @(posedge clk);
      bif_b.rd_data <= mem_b[bif_b.rd_addr];
    end
  end

  // LED chain capture: each cko rise clocks one bit into the chain.
  initial forever begin
    @(posedge bif_a.cko);
    a_q.push_back(bif_a.sdo);
  end

  initial begin : rise_b
    time last;
    last = 0;
    forever begin
      @(posedge bif_b.cko);
      b_q.push_back(bif_b.sdo);
      if ((b_q.size() - 1) % 24 != 0) check("b_cko_period", 72'($time - last), 72'd20);
      last = $time;
    end
  end

  // Reference model for A, compared every cycle.
  initial begin : model_a
    bit act, dn, hi;
    int t, addr, kind, led, bn;
    logic e_sdo, e_cko;
    act = 0; dn = 0; t = 0; addr = 0;
    forever begin
      @(posedge clk);
      dn = 0;
      if (rst_a) begin
        act = 0; addr = 0;
      end else if (act) begin
        if (t == A_FRAME - 1) begin act = 0; dn = 1; end
        else t++;
      end else if (bif_a.start === 1'b1) begin
        act = 1; t = 0;
      end
      #1;
      e_sdo = 1'b0; e_cko = 1'b0;
      if (act) begin
        frame_pos(A_LEDS, A_CD, t, kind, led, bn, hi);
        addr = led;
        if (kind == 1) begin
          e_cko = hi;
          e_sdo = mem_a[led][23 - bn];
        end else if (kind == 0 && led > 0) begin
          e_sdo = mem_a[led - 1][0];
        end
      end
      check("a_outputs", {bif_a.sdo, bif_a.cko, bif_a.busy, bif_a.done, bif_a.rd_addr},
            {e_sdo, e_cko, act, dn, 2'(addr)});
    end
  end

  // Reference model for B, compared every cycle.
  initial begin : model_b
    bit act, dn, hi;
    int t, addr, kind, led, bn;
    logic e_sdo, e_cko;
    act = 0; dn = 0; t = 0; addr = 0;
    forever begin
      @(posedge clk);
      dn = 0;
      if (rst_b) begin
        act = 0; addr = 0;
      end else if (act) begin
        if (t == B_FRAME - 1) begin act = 0; dn = 1; end
        else t++;
      end else if (bif_b.start === 1'b1) begin
        act = 1; t = 0;
      end
      #1;
      e_sdo = 1'b0; e_cko = 1'b0;
      if (act) begin
        frame_pos(B_LEDS, B_CD, t, kind, led, bn, hi);
        addr = led;
        if (kind == 1) begin
          e_cko = hi;
          e_sdo = mem_b[led][23 - bn];
        end else if (kind == 0 && led > 0) begin
          e_sdo = mem_b[led - 1][0];
        end
      end
      check("b_outputs", {bif_b.sdo, bif_b.cko, bif_b.busy, bif_b.done, bif_b.rd_addr},
            {e_sdo, e_cko, act, dn, 6'(addr)});
    end
  end

  // Caller raises start at a negedge; runs the frame to done and checks it.
  // extras: 0 none, 1 start pulses mid-shift and mid-latch, 2 random pulses.
  task automatic frame_a(input int extras, input bit chain);
    int base, cyc;
    base = a_q.size();
    @(negedge clk);
    bif_a.start = 1'b0;
    check("a_busy_rise", 72'(bif_a.busy), 72'd1);
    cyc = 0;
    while (bif_a.done !== 1'b1 && cyc < 2 * A_FRAME) begin
      @(negedge clk);
      cyc++;
      if (extras == 1) bif_a.start = (cyc == 100 || cyc == 300);
      else if (extras == 2) bif_a.start = ($urandom_range(0, 15) == 0);
    end
    bif_a.start = chain;
    check("a_frame_cycles", 72'(cyc), 72'd314);
    check("a_cko_rises", 72'(a_q.size() - base), 72'd72);
    for (int i = 0; i < A_LEDS; i++) begin
      a_got[i] = '0;
      for (int j = 0; j < 24; j++)
        if (base + 24 * i + j < a_q.size()) a_got[i] = {a_got[i][22:0], a_q[base + 24 * i + j]};
      check($sformatf("a_led%0d", i), 72'(a_got[i]), 72'(mem_a[i]));
    end
    if (chain) mem_a = nxt_a;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base, cyc, dones;
    logic [71:0] bits;
    logic [23:0] led_val;
    rst_a = 1'b1; rst_b = 1'b1;
    bif_a.start = 1'b0; bif_b.start = 1'b0;
    for (int i = 0; i < A_LEDS; i++) mem_a[i] = '0;
    for (int i = 0; i < B_LEDS; i++) mem_b[i] = '0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("a_reset_values", {bif_a.sdo, bif_a.cko, bif_a.busy, bif_a.done, bif_a.rd_addr}, '0);
    check("b_reset_values", {bif_b.sdo, bif_b.cko, bif_b.busy, bif_b.done, bif_b.rd_addr}, '0);

    // Idle with no start.
    base = a_q.size();
    repeat (100) @(negedge clk);
    check("a_idle_no_edges", 72'(a_q.size() - base), 72'd0);
    check("b_idle_no_edges", 72'(b_q.size()), 72'd0);
    check("a_idle_outputs", {bif_a.sdo, bif_a.cko, bif_a.busy, bif_a.done, bif_a.rd_addr}, '0);

    // Single frame with ignored start pulses, chained into a second frame.
    mem_a = '{24'hFF0000, 24'h00FF00, 24'h0000FF};
    nxt_a = '{24'h123456, 24'hA5C33C, 24'h0F0F0F};
    base  = a_q.size();
    bif_a.start = 1'b1;
    frame_a(1, 1'b1);
    bits = '0;
    for (int i = 0; i < 72; i++)
      if (base + i < a_q.size()) bits = {bits[70:0], a_q[base + i]};
    check("a_frame1_bitstream", bits, 72'hFF0000_00FF00_0000FF);

    // Second frame began on the done cycle; LED 1 depends on read timing.
    frame_a(0, 1'b0);
    check("a_led1_read_timing", 72'(a_got[1]), 72'hA5C33C);

    // Random colors, random gaps, random stray start pulses.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < A_LEDS; i++) mem_a[i] = 24'($urandom);
      repeat ($urandom_range(0, 10)) @(negedge clk);
      bif_a.start = 1'b1;
      frame_a(2, 1'b0);
    end
    @(negedge clk);

    // Asynchronous reset during bit 10 of LED 1.
    for (int i = 0; i < A_LEDS; i++) mem_a[i] = 24'($urandom);
    bif_a.start = 1'b1;
    @(negedge clk);
    bif_a.start = 1'b0;
    repeat (142) @(negedge clk);
    check("a_pre_reset_cko", 72'(bif_a.cko), 72'd1);
    #1 rst_a = 1'b1;
    #1;
    check("a_async_reset", {bif_a.sdo, bif_a.cko, bif_a.busy, bif_a.done, bif_a.rd_addr}, '0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    dones = 0;
    base  = a_q.size();
    repeat (A_FRAME) begin
      @(negedge clk);
      if (bif_a.done === 1'b1) dones++;
    end
    check("a_no_done_after_reset", 72'(dones), 72'd0);
    check("a_no_edges_after_reset", 72'(a_q.size() - base), 72'd0);
    bif_a.start = 1'b1;
    frame_a(0, 1'b0);

    // 50 LEDs, CLK_DIV = 1, incrementing colors.
    for (int i = 0; i < B_LEDS; i++) mem_b[i] = 24'(i * 32'h010203);
    base = b_q.size();
    @(negedge clk);
    bif_b.start = 1'b1;
    @(negedge clk);
    bif_b.start = 1'b0;
    check("b_busy_rise", 72'(bif_b.busy), 72'd1);
    cyc = 0;
    while (bif_b.done !== 1'b1 && cyc < 2 * B_FRAME) begin
      @(negedge clk);
      cyc++;
    end
    check("b_frame_cycles", 72'(cyc), 72'd2516);
    check("b_cko_rises", 72'(b_q.size() - base), 72'd1200);
    for (int i = 0; i < B_LEDS; i++) begin
      led_val = '0;
      for (int j = 0; j < 24; j++)
        if (base + 24 * i + j < b_q.size()) led_val = {led_val[22:0], b_q[base + 24 * i + j]};
      check($sformatf("b_led%0d", i), 72'(led_val), 72'(24'(i * 32'h010203)));
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
